// File: rtl/shift_pkg.sv
// Shared types, constants and the bit-reversal helper for the iterative shifter.
package shift_pkg;

    localparam int SHIFT_WIDTH = 32;
    localparam int SHIFT_STEPS = 5;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_RSVD = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    function automatic logic [SHIFT_WIDTH-1:0] bitrev32(input logic [SHIFT_WIDTH-1:0] x);
        logic [SHIFT_WIDTH-1:0] r;
        for (int i = 0; i < SHIFT_WIDTH; i++) begin
            r[i] = x[SHIFT_WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One left-shift step by 2^k with a fill bit; passes data through when disabled.
module shift_step
    import shift_pkg::*;
(
    input  logic [SHIFT_WIDTH-1:0] i_data,
    input  logic [2:0]             i_k,
    input  logic                   i_en,
    input  logic                   i_fill,
    output logic [SHIFT_WIDTH-1:0] o_data
);

    logic [SHIFT_WIDTH-1:0] w_cand [SHIFT_STEPS];

    genvar gi;
    generate
        for (gi = 0; gi < SHIFT_STEPS; gi++) begin : g_dist
            localparam int DIST = 1 << gi;
            assign w_cand[gi] = {i_data[SHIFT_WIDTH-1-DIST:0], {DIST{i_fill}}};
        end
    endgenerate

    always_comb begin
        o_data = i_data;
        for (int i = 0; i < SHIFT_STEPS; i++) begin
            if (i_en && (i_k == 3'(i))) begin
                o_data = w_cand[i];
            end
        end
    end

endmodule

// File: rtl/iterative_shift_ctrl.sv
// Five-cycle SLL/SRL/SRA unit; right shifts run as left shifts on the bit-reversed operand.
module iterative_shift_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int STEPS = SHIFT_STEPS
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Start,
    input  logic             Flush,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] In,
    input  logic [STEPS-1:0] Shamt,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Out
);

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_k;
    logic [WIDTH-1:0] r_w;
    shift_op_t        r_op;
    logic [STEPS-1:0] r_shamt;
    logic             r_fill;
    logic [WIDTH-1:0] r_out;

    logic             w_ready;
    logic             w_accept;
    logic             w_last;
    logic             w_step_en;
    logic             w_rev_op;
    logic             w_in_rev;
    shift_op_t        w_in_op;
    logic [WIDTH-1:0] w_step_out;

    assign w_ready   = (r_state == IDLE) || (r_state == DONE);
    assign w_accept  = Start && w_ready && !Flush;
    assign w_last    = (r_k == 3'(STEPS-1));
    assign w_in_op   = shift_op_t'(Op);
    assign w_in_rev  = (w_in_op == SHIFT_SRL) || (w_in_op == SHIFT_SRA);
    assign w_rev_op  = (r_op == SHIFT_SRL) || (r_op == SHIFT_SRA);

    always_comb begin
        w_step_en = 1'b0;
        for (int i = 0; i < STEPS; i++) begin
            if (r_k == 3'(i)) begin
                w_step_en = r_shamt[i];
            end
        end
    end

    shift_step u_step (
        .i_data (r_w),
        .i_k    (r_k),
        .i_en   (w_step_en),
        .i_fill (r_fill),
        .o_data (w_step_out)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (Flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept) w_state_next = SHIFT;
                SHIFT:   if (w_last)   w_state_next = DONE;
                DONE:    w_state_next = w_accept ? SHIFT : IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Flush only clears sequencing; the last completed result stays on Out.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_k     <= '0;
            r_w     <= '0;
            r_op    <= SHIFT_SLL;
            r_shamt <= '0;
            r_fill  <= 1'b0;
            r_out   <= '0;
        end else if (Flush) begin
            r_k <= '0;
        end else if (w_accept) begin
            r_k     <= '0;
            r_op    <= w_in_op;
            r_shamt <= Shamt;
            r_w     <= w_in_rev ? bitrev32(In) : In;
            r_fill  <= (w_in_op == SHIFT_SRA) ? In[WIDTH-1] : 1'b0;
        end else if (r_state == SHIFT) begin
            r_w <= w_step_out;
            if (w_last) begin
                r_k   <= '0;
                r_out <= w_rev_op ? bitrev32(w_step_out) : w_step_out;
            end else begin
                r_k <= r_k + 3'd1;
            end
        end
    end

    assign Ready = w_ready;
    assign Done  = (r_state == DONE);
    assign Out   = r_out;

endmodule

// File: tb/tb_iterative_shift_ctrl.sv
// Randomized and directed checks of iterative_shift_ctrl against an arithmetic shift model.
module tb_iterative_shift_ctrl;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] In = '0;
    logic [4:0]  Shamt = '0;
    logic        Ready;
    logic        Done;
    logic [31:0] Out;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    iterative_shift_ctrl dut (
        .Clock  (Clock),
        .nReset (nReset),
        .Start  (Start),
        .Flush  (Flush),
        .Op     (Op),
        .In     (In),
        .Shamt  (Shamt),
        .Ready  (Ready),
        .Done   (Done),
        .Out    (Out)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) if (Done) done_cnt++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] x,
                                              input logic [4:0] s);
        case (op)
            2'b01:   return x >> s;
            2'b10:   return 32'($signed(x) >>> s);
            default: return x << s;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic scramble_inputs();
        Op    = 2'($urandom);
        In    = $urandom;
        Shamt = 5'($urandom);
    endtask

    // Accepts one operation, waits for Done, and checks latency and result.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] x,
                          input logic [4:0] s);
        int n;
        Op = op; In = x; Shamt = s; Start = 1'b1;
        tick();
        Start = 1'b0;
        scramble_inputs();
        n = 0;
        while (!Done && n < 12) begin
            tick();
            n++;
        end
        check_val({tag, "_lat"}, 32'(n), 32'd5);
        check_val({tag, "_out"}, Out, ref_shift(op, x, s));
    endtask

    initial begin
        int n;
        int d0;
        logic [31:0] held;

        #2;
        check_val("rst_ready", 32'(Ready), 32'd1);
        check_val("rst_done", 32'(Done), 32'd0);
        check_val("rst_out", Out, 32'h0);
        tick();
        nReset = 1'b1;
        tick();

        run_op("sll_31", 2'b00, 32'h0000_0001, 5'd31);
        check_val("sll_31_val", Out, 32'h8000_0000);
        tick();
        run_op("sll_4", 2'b00, 32'h1234_5678, 5'd4);
        check_val("sll_4_val", Out, 32'h2345_6780);
        tick();
        run_op("srl_4", 2'b01, 32'h8000_00F0, 5'd4);
        check_val("srl_4_val", Out, 32'h0800_000F);
        tick();
        run_op("sra_4", 2'b10, 32'h8000_00F0, 5'd4);
        check_val("sra_4_val", Out, 32'hF800_000F);
        tick();
        run_op("sra_31", 2'b10, 32'h8000_0000, 5'd31);
        check_val("sra_31_val", Out, 32'hFFFF_FFFF);
        tick();
        run_op("sra_0", 2'b10, 32'hDEAD_BEEF, 5'd0);
        check_val("sra_0_val", Out, 32'hDEAD_BEEF);
        tick();
        run_op("rsvd_1", 2'b11, 32'h0000_0001, 5'd1);
        check_val("rsvd_1_val", Out, 32'h0000_0002);
        held = Out;
        repeat (3) tick();
        check_val("out_hold", Out, held);

        // Start pulsed mid-SHIFT must not disturb the operation in flight
        Op = 2'b00; In = 32'h0000_00A5; Shamt = 5'd3; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        n = 1;
        check_val("busy_ready", 32'(Ready), 32'd0);
        Op = 2'b01; In = 32'hFFFF_0000; Shamt = 5'd7; Start = 1'b1;
        tick();
        n++;
        Start = 1'b0;
        while (!Done && n < 12) begin
            tick();
            n++;
        end
        check_val("ign_lat", 32'(n), 32'd5);
        check_val("ign_out", Out, 32'h0000_0528);
        tick();
        d0 = done_cnt;
        repeat (8) tick();
        check_val("ign_no_done", 32'(done_cnt - d0), 32'd0);

        // Back-to-back accept during DONE
        run_op("b2b_a", 2'b10, 32'h9000_0001, 5'd2);
        Op = 2'b01; In = 32'hF000_000F; Shamt = 5'd8; Start = 1'b1;
        tick();
        Start = 1'b0;
        n = 1;
        while (!Done && n < 14) begin
            tick();
            n++;
        end
        check_val("b2b_gap", 32'(n), 32'd6);
        check_val("b2b_out", Out, 32'h00F0_0000);
        tick();

        // Flush at k=2
        held = Out;
        Op = 2'b00; In = 32'h0000_FFFF; Shamt = 5'd9; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check_val("flush_ready", 32'(Ready), 32'd1);
        check_val("flush_done", 32'(Done), 32'd0);
        d0 = done_cnt;
        repeat (8) tick();
        check_val("flush_no_done", 32'(done_cnt - d0), 32'd0);
        check_val("flush_out", Out, held);

        // Flush and Start together in IDLE
        Op = 2'b00; In = 32'h1; Shamt = 5'd1; Start = 1'b1; Flush = 1'b1;
        tick();
        Start = 1'b0; Flush = 1'b0;
        check_val("fs_ready", 32'(Ready), 32'd1);
        d0 = done_cnt;
        repeat (8) tick();
        check_val("fs_no_done", 32'(done_cnt - d0), 32'd0);
        check_val("fs_out", Out, held);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  rop;
            logic [31:0] rx;
            logic [4:0]  rs;
            rop = 2'($urandom);
            rx  = $urandom;
            rs  = 5'($urandom);
            run_op($sformatf("rnd%0d", i), rop, rx, rs);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();

        // Reset asserted mid-SHIFT
        run_op("pre_rst", 2'b00, 32'hCAFE_0001, 5'd5);
        tick();
        Op = 2'b01; In = 32'h8765_4321; Shamt = 5'd3; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        nReset = 1'b0;
        #1;
        check_val("mid_rst_ready", 32'(Ready), 32'd1);
        check_val("mid_rst_done", 32'(Done), 32'd0);
        check_val("mid_rst_out", Out, 32'h0);
        d0 = done_cnt;
        tick();
        tick();
        nReset = 1'b1;
        repeat (10) tick();
        check_val("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check_val("mid_rst_out_after", Out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
